// File: rtl/dac_ram_loader_ctrl.sv
// Loads sequence/RNG sample RAMs from a command stream, then arms and starts DAC playout
// on the first PPS rising edge after COMMIT.
module dac_ram_loader_ctrl #(
    parameter int unsigned SEQ_DEPTH   = 1024,
    parameter int unsigned RNG_DEPTH   = 4096,
    parameter int unsigned PPS_TIMEOUT = 250000000
) (
    input  logic        tx_core_clk,
    input  logic        tx_core_reset,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    input  logic [47:0] cmd_tdata,
    input  logic        pps_i,
    output logic        seq_wen_o,
    output logic [9:0]  seq_addr_o,
    output logic [31:0] seq_din_o,
    output logic        rng_wen_o,
    output logic [11:0] rng_addr_o,
    output logic [31:0] rng_din_o,
    output logic [9:0]  max_addr_seq_o,
    output logic [11:0] max_addr_rng_o,
    output logic        shift_en_o,
    output logic [1:0]  state_o,
    output logic        err_o
);

    // The ARMED counter runs 0..PPS_TIMEOUT-1, so the timeout fires on the PPS_TIMEOUT-th cycle.
    localparam int unsigned CntW = (PPS_TIMEOUT > 1) ? $clog2(PPS_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PPS_TIMEOUT - 1);

    localparam logic [1:0] OpSeqWr  = 2'b00;
    localparam logic [1:0] OpRngWr  = 2'b01;
    localparam logic [1:0] OpCommit = 2'b10;
    localparam logic [1:0] OpAbort  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StArmed = 2'd2,
        StRun   = 2'd3
    } state_e;

    state_e          state_q;
    logic            seq_wen_q, rng_wen_q;
    logic [9:0]      seq_addr_q;
    logic [11:0]     rng_addr_q;
    logic [31:0]     seq_din_q, rng_din_q;
    logic [9:0]      seq_max_q, max_seq_q;
    logic [11:0]     rng_max_q, max_rng_q;
    logic            seq_written_q, rng_written_q;
    logic            shift_en_q, err_q, pps_q;
    logic [CntW-1:0] cnt_q;

    logic        cmd_fire;
    logic [1:0]  cmd_op;
    logic [13:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        seq_ok, rng_ok, seq_bump, rng_bump, pps_rise, timeout;

    assign cmd_tready = ~tx_core_reset;
    assign cmd_fire   = cmd_tvalid & cmd_tready;
    assign cmd_op     = cmd_tdata[47:46];
    assign cmd_addr   = cmd_tdata[45:32];
    assign cmd_data   = cmd_tdata[31:0];

    assign seq_ok   = 32'(cmd_addr) < SEQ_DEPTH;
    assign rng_ok   = 32'(cmd_addr) < RNG_DEPTH;
    // First write after IDLE always restarts the running maximum.
    assign seq_bump = (state_q == StIdle) || !seq_written_q || (cmd_addr[9:0] > seq_max_q);
    assign rng_bump = (state_q == StIdle) || !rng_written_q || (cmd_addr[11:0] > rng_max_q);
    assign pps_rise = pps_i & ~pps_q;
    assign timeout  = (cnt_q == CntLast);

    always_ff @(posedge tx_core_clk) begin
        if (tx_core_reset) begin
            state_q       <= StIdle;
            seq_wen_q     <= 1'b0;
            rng_wen_q     <= 1'b0;
            seq_addr_q    <= '0;
            rng_addr_q    <= '0;
            seq_din_q     <= '0;
            rng_din_q     <= '0;
            seq_max_q     <= '0;
            rng_max_q     <= '0;
            max_seq_q     <= '0;
            max_rng_q     <= '0;
            seq_written_q <= 1'b0;
            rng_written_q <= 1'b0;
            shift_en_q    <= 1'b0;
            err_q         <= 1'b0;
            pps_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            seq_wen_q <= 1'b0;
            rng_wen_q <= 1'b0;
            pps_q     <= pps_i;
            if (cmd_fire && cmd_op == OpAbort) begin
                state_q    <= StIdle;
                shift_en_q <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StLoad: begin
                        if (cmd_fire) begin
                            unique case (cmd_op)
                                OpSeqWr: begin
                                    if (seq_ok) begin
                                        seq_wen_q     <= 1'b1;
                                        seq_addr_q    <= cmd_addr[9:0];
                                        seq_din_q     <= cmd_data;
                                        seq_written_q <= 1'b1;
                                        if (seq_bump) seq_max_q <= cmd_addr[9:0];
                                        if (state_q == StIdle) begin
                                            state_q       <= StLoad;
                                            rng_written_q <= 1'b0;
                                        end
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                OpRngWr: begin
                                    if (rng_ok) begin
                                        rng_wen_q     <= 1'b1;
                                        rng_addr_q    <= cmd_addr[11:0];
                                        rng_din_q     <= cmd_data;
                                        rng_written_q <= 1'b1;
                                        if (rng_bump) rng_max_q <= cmd_addr[11:0];
                                        if (state_q == StIdle) begin
                                            state_q       <= StLoad;
                                            seq_written_q <= 1'b0;
                                        end
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                OpCommit: begin
                                    if (state_q == StLoad && seq_written_q) begin
                                        max_seq_q <= seq_max_q;
                                        max_rng_q <= rng_written_q ? rng_max_q : '0;
                                        state_q   <= StArmed;
                                        cnt_q     <= '0;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    StArmed: begin
                        if (pps_rise) begin
                            state_q    <= StRun;
                            shift_en_q <= 1'b1;
                        end else if (timeout) begin
                            state_q <= StLoad;
                            err_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (cmd_fire) err_q <= 1'b1;
                    end
                    StRun: begin
                        if (cmd_fire) err_q <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign seq_wen_o      = seq_wen_q;
    assign seq_addr_o     = seq_addr_q;
    assign seq_din_o      = seq_din_q;
    assign rng_wen_o      = rng_wen_q;
    assign rng_addr_o     = rng_addr_q;
    assign rng_din_o      = rng_din_q;
    assign max_addr_seq_o = max_seq_q;
    assign max_addr_rng_o = max_rng_q;
    assign shift_en_o     = shift_en_q;
    assign state_o        = state_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_dac_ram_loader_ctrl.sv
// Directed bench for dac_ram_loader_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed checkpoints.
module tb_dac_ram_loader_ctrl;

    localparam int TIMEOUT = 100;
    localparam logic [1:0] SEQ = 2'b00, RNG = 2'b01, COM = 2'b10, ABT = 2'b11;

    logic        clk = 1'b0;
    logic        tx_core_reset, cmd_tvalid, cmd_tready, pps_i;
    logic [47:0] cmd_tdata;
    logic        seq_wen_o, rng_wen_o, shift_en_o, err_o;
    logic [9:0]  seq_addr_o, max_addr_seq_o;
    logic [11:0] rng_addr_o, max_addr_rng_o;
    logic [31:0] seq_din_o, rng_din_o;
    logic [1:0]  state_o;

    dac_ram_loader_ctrl #(.SEQ_DEPTH(1024), .RNG_DEPTH(4096), .PPS_TIMEOUT(TIMEOUT)) dut (
        .tx_core_clk   (clk),
        .tx_core_reset (tx_core_reset),
        .cmd_tvalid    (cmd_tvalid),
        .cmd_tready    (cmd_tready),
        .cmd_tdata     (cmd_tdata),
        .pps_i         (pps_i),
        .seq_wen_o     (seq_wen_o),
        .seq_addr_o    (seq_addr_o),
        .seq_din_o     (seq_din_o),
        .rng_wen_o     (rng_wen_o),
        .rng_addr_o    (rng_addr_o),
        .rng_din_o     (rng_din_o),
        .max_addr_seq_o(max_addr_seq_o),
        .max_addr_rng_o(max_addr_rng_o),
        .shift_en_o    (shift_en_o),
        .state_o       (state_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_on = 1'b0;
    bit rst_lvl = 1'b1, pps_lvl = 1'b0;
    int sw_cnt = 0, rw_cnt = 0;

    // Behavioural model; seq_hi/rng_hi of -1 mean "nothing written since IDLE".
    int m_state, m_err, m_shift, m_sw, m_rw, m_sa, m_ra, m_mseq, m_mrng, m_cnt;
    int seq_hi, rng_hi;
    logic [31:0] m_sd, m_rd;
    bit m_pprev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [47:0] d, input bit p, input bit r);
        int op, a;
        bit rise;
        op = int'(d[47:46]);
        a  = int'(d[45:32]);
        if (r) begin
            m_state = 0; m_err = 0; m_shift = 0; m_sw = 0; m_rw = 0;
            m_sa = 0; m_ra = 0; m_sd = 0; m_rd = 0; m_mseq = 0; m_mrng = 0;
            m_cnt = 0; m_pprev = 0; seq_hi = -1; rng_hi = -1;
            return;
        end
        m_sw = 0; m_rw = 0;
        rise = p && !m_pprev;
        m_pprev = p;
        if (v && op == 3) begin
            m_state = 0; m_shift = 0; m_err = 0;
        end else if (m_state <= 1) begin
            if (v && op <= 1) begin
                if (a < ((op == 0) ? 1024 : 4096)) begin
                    if (m_state == 0) begin
                        seq_hi = -1; rng_hi = -1; m_state = 1;
                    end
                    if (op == 0) begin
                        m_sw = 1; m_sa = a; m_sd = d[31:0];
                        if (a > seq_hi) seq_hi = a;
                    end else begin
                        m_rw = 1; m_ra = a; m_rd = d[31:0];
                        if (a > rng_hi) rng_hi = a;
                    end
                end else begin
                    m_err = 1;
                end
            end else if (v && op == 2) begin
                if (m_state == 1 && seq_hi >= 0) begin
                    m_mseq = seq_hi; m_mrng = (rng_hi < 0) ? 0 : rng_hi;
                    m_state = 2; m_cnt = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_state == 2) begin
            m_cnt++;
            if (rise) begin
                m_state = 3; m_shift = 1;
            end else if (m_cnt == TIMEOUT) begin
                m_state = 1; m_err = 1;
            end
            if (v) m_err = 1;
        end else if (v) begin
            m_err = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tready", 32'(cmd_tready), 32'(!tx_core_reset));
            chk("state", 32'(state_o), m_state);
            chk("err", 32'(err_o), m_err);
            chk("shift_en", 32'(shift_en_o), m_shift);
            chk("seq_wen", 32'(seq_wen_o), m_sw);
            chk("rng_wen", 32'(rng_wen_o), m_rw);
            chk("seq_addr", 32'(seq_addr_o), m_sa);
            chk("seq_din", seq_din_o, m_sd);
            chk("rng_addr", 32'(rng_addr_o), m_ra);
            chk("rng_din", rng_din_o, m_rd);
            chk("max_seq", 32'(max_addr_seq_o), m_mseq);
            chk("max_rng", 32'(max_addr_rng_o), m_mrng);
            chk("wen_exclusive", 32'(seq_wen_o & rng_wen_o), 0);
        end
    end

    always @(posedge clk) begin
        if (seq_wen_o === 1'b1) sw_cnt++;
        if (rng_wen_o === 1'b1) rw_cnt++;
    end

    function automatic logic [47:0] mk(input logic [1:0] op, input int a, input logic [31:0] dat);
        return {op, a[13:0], dat};
    endfunction

    task automatic tick(input bit v, input logic [47:0] d);
        cmd_tvalid    = v;
        cmd_tdata     = d;
        pps_i         = pps_lvl;
        tx_core_reset = rst_lvl;
        @(posedge clk);
        model_step(v, d, pps_lvl, rst_lvl);
        #2;
        cmd_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 48'd0);
    endtask

    int s0, r0;

    initial begin
        cmd_tvalid = 1'b0; cmd_tdata = '0; pps_i = 1'b0; tx_core_reset = 1'b1;
        tick(1'b0, 48'd0);
        chk_on = 1'b1;
        tick(1'b1, mk(SEQ, 1, 32'h1));
        chk("rst_tready", 32'(cmd_tready), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_no_wen", 32'(seq_wen_o), 0);
        chk("rst_max_seq", 32'(max_addr_seq_o), 0);
        rst_lvl = 1'b0;
        idle(1);

        // Basic load and commit
        s0 = sw_cnt; r0 = rw_cnt;
        tick(1'b1, mk(SEQ, 0, 32'hA));
        chk("wr0_wen", 32'(seq_wen_o), 1);
        chk("wr0_din", seq_din_o, 32'hA);
        chk("wr0_state", 32'(state_o), 1);
        tick(1'b1, mk(SEQ, 5, 32'h55));
        tick(1'b1, mk(RNG, 3, 32'h33));
        tick(1'b1, mk(COM, 0, 0));
        chk("commit_max_seq", 32'(max_addr_seq_o), 5);
        chk("commit_max_rng", 32'(max_addr_rng_o), 3);
        chk("commit_state", 32'(state_o), 2);
        idle(2);
        chk("seq_pulses", sw_cnt - s0, 2);
        chk("rng_pulses", rw_cnt - r0, 1);

        // PPS edge starts playout one cycle later; later edges change nothing
        pps_lvl = 1'b1;
        tick(1'b0, 48'd0);
        chk("pps_state", 32'(state_o), 3);
        chk("pps_shift", 32'(shift_en_o), 1);
        pps_lvl = 1'b0; idle(1); pps_lvl = 1'b1; idle(1); pps_lvl = 1'b0;
        chk("run_hold", 32'(shift_en_o), 1);

        // Commands rejected while running
        tick(1'b1, mk(SEQ, 7, 32'h7));
        chk("run_wr_err", 32'(err_o), 1);
        chk("run_wr_nowen", 32'(seq_wen_o), 0);
        chk("run_wr_shift", 32'(shift_en_o), 1);
        tick(1'b1, mk(COM, 0, 0));
        chk("run_com_state", 32'(state_o), 3);
        tick(1'b1, mk(ABT, 0, 0));
        chk("abort_shift", 32'(shift_en_o), 0);
        chk("abort_state", 32'(state_o), 0);
        chk("abort_err", 32'(err_o), 0);
        chk("abort_keep_max", 32'(max_addr_seq_o), 5);

        // PPS edge coincident with COMMIT is ignored
        tick(1'b1, mk(SEQ, 2, 32'h2));
        pps_lvl = 1'b1;
        tick(1'b1, mk(COM, 0, 0));
        idle(4);
        chk("pps_at_commit_ignored", 32'(state_o), 2);
        chk("unwritten_rng_max", 32'(max_addr_rng_o), 0);
        chk("rearm_max_seq", 32'(max_addr_seq_o), 2);
        pps_lvl = 1'b0; idle(1); pps_lvl = 1'b1;
        tick(1'b0, 48'd0);
        chk("late_pps_state", 32'(state_o), 3);
        pps_lvl = 1'b0;
        tick(1'b1, mk(ABT, 0, 0));

        // Address range boundaries
        tick(1'b1, mk(SEQ, 1024, 32'hBAD));
        chk("seq_oor_err", 32'(err_o), 1);
        chk("seq_oor_state", 32'(state_o), 0);
        chk("seq_oor_nowen", 32'(seq_wen_o), 0);
        tick(1'b1, mk(RNG, 4096, 32'hBAD));
        chk("rng_oor_nowen", 32'(rng_wen_o), 0);
        tick(1'b1, mk(RNG, 4095, 32'hF));
        chk("rng_top_addr", 32'(rng_addr_o), 4095);
        chk("rng_top_wen", 32'(rng_wen_o), 1);
        tick(1'b1, mk(SEQ, 1023, 32'hE));
        chk("seq_top_addr", 32'(seq_addr_o), 1023);
        tick(1'b1, mk(ABT, 0, 0));
        chk("oor_abort_err", 32'(err_o), 0);

        // COMMIT without any sequence write, and COMMIT from IDLE
        tick(1'b1, mk(RNG, 10, 32'h10));
        tick(1'b1, mk(COM, 0, 0));
        chk("com_noseq_err", 32'(err_o), 1);
        chk("com_noseq_state", 32'(state_o), 1);
        tick(1'b1, mk(ABT, 0, 0));
        tick(1'b1, mk(COM, 0, 0));
        chk("com_idle_err", 32'(err_o), 1);
        chk("com_idle_state", 32'(state_o), 0);
        tick(1'b1, mk(ABT, 0, 0));

        // PPS timeout returns to LOAD with maxima retained
        tick(1'b1, mk(SEQ, 9, 32'h9));
        tick(1'b1, mk(RNG, 20, 32'h20));
        tick(1'b1, mk(COM, 0, 0));
        idle(TIMEOUT - 1);
        chk("pre_timeout_state", 32'(state_o), 2);
        idle(1);
        chk("timeout_state", 32'(state_o), 1);
        chk("timeout_err", 32'(err_o), 1);
        chk("timeout_shift", 32'(shift_en_o), 0);
        tick(1'b1, mk(COM, 0, 0));
        chk("recommit_state", 32'(state_o), 2);
        chk("recommit_max_rng", 32'(max_addr_rng_o), 20);
        pps_lvl = 1'b1;
        tick(1'b0, 48'd0);
        pps_lvl = 1'b0;
        chk("recommit_run", 32'(state_o), 3);

        // Reset during RUN
        rst_lvl = 1'b1;
        tick(1'b0, 48'd0);
        chk("rrun_state", 32'(state_o), 0);
        chk("rrun_shift", 32'(shift_en_o), 0);
        chk("rrun_err", 32'(err_o), 0);
        chk("rrun_max_rng", 32'(max_addr_rng_o), 0);
        chk("rrun_rng_addr", 32'(rng_addr_o), 0);
        rst_lvl = 1'b0;
        idle(1);

        // Reset while a write pulse is in flight
        tick(1'b1, mk(SEQ, 6, 32'h66));
        chk("rwen_pulse", 32'(seq_wen_o), 1);
        s0 = sw_cnt;
        rst_lvl = 1'b1;
        tick(1'b0, 48'd0);
        rst_lvl = 1'b0;
        idle(3);
        chk("rwen_no_more", sw_cnt - s0, 1);
        chk("rwen_addr", 32'(seq_addr_o), 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_ram_loader_ctrl.md
DAC_RAM_LOADER_CTRL -- requirements
Module: dac_ram_loader_ctrl

Interface
REQ-001 SHALL have parameter SEQ_DEPTH, default 1024: number of sequence RAM words.
REQ-002 SHALL have parameter RNG_DEPTH, default 4096: number of RNG RAM words.
REQ-003 SHALL have parameter PPS_TIMEOUT, default 250000000: maximum cycles spent in ARMED waiting for PPS.
REQ-004 SHALL have port tx_core_clk  in  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port tx_core_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_tvalid  in  1  command valid.
REQ-007 SHALL have port cmd_tready  out  1  command ready.
REQ-008 SHALL have port cmd_tdata  in  48  command: [47:46] op (00 SEQ_WR, 01 RNG_WR, 10 COMMIT, 11 ABORT), [45:32] addr, [31:0] data.
REQ-009 SHALL have port pps_i  in  1  pulse-per-second, already synchronous to tx_core_clk.
REQ-010 SHALL have ports seq_wen_o  out  1, seq_addr_o  out  10, seq_din_o  out  32: sequence RAM write port.
REQ-011 SHALL have ports rng_wen_o  out  1, rng_addr_o  out  12, rng_din_o  out  32: RNG RAM write port.
REQ-012 SHALL have ports max_addr_seq_o  out  10 and max_addr_rng_o  out  12: committed highest written address per RAM.
REQ-013 SHALL have port shift_en_o  out  1: enables DAC sample playout.
REQ-014 SHALL have ports state_o  out  2 (current state encoding) and err_o  out  1 (sticky error flag).

Function
REQ-015 SHALL implement states IDLE=0, LOAD=1, ARMED=2, RUN=3.
REQ-016 SHALL drive cmd_tready=1 in every state except during reset; a command is accepted on any cycle with cmd_tvalid & cmd_tready.
REQ-017 SHALL on an accepted SEQ_WR/RNG_WR in IDLE or LOAD with in-range addr: assert the matching wen for exactly one cycle, in the next cycle, with addr/din registered; IDLE moves to LOAD.
REQ-018 SHALL treat addr >= SEQ_DEPTH (SEQ_WR) or addr >= RNG_DEPTH (RNG_WR) as an error: no wen, err_o set, state unchanged.
REQ-019 SHALL track in LOAD the highest in-range addr written per RAM plus a per-RAM "written" bit; both are cleared on entry to LOAD from IDLE.
REQ-020 SHALL on COMMIT in LOAD with at least one SEQ_WR done: copy tracked maxima to max_addr_seq_o/max_addr_rng_o (unwritten RNG gives 0) and enter ARMED next cycle.
REQ-021 SHALL on COMMIT in LOAD with no SEQ_WR, or COMMIT in IDLE/ARMED/RUN: set err_o, no state change.
REQ-022 SHALL in ARMED detect the PPS rising edge (pps_i=1, previous-cycle pps_i=0); enter RUN on the cycle after the edge, and shift_en_o goes 1 in that same cycle.
REQ-023 SHALL ignore a PPS edge that occurs in the same cycle as the COMMIT acceptance.
REQ-024 SHALL count cycles in ARMED; on reaching PPS_TIMEOUT without a PPS edge, set err_o and return to LOAD, retaining tracked maxima.
REQ-025 SHALL in ARMED and RUN reject SEQ_WR/RNG_WR (no wen, err_o set); RAMs are not modified while armed or playing.
REQ-026 SHALL on ABORT in any state: go to IDLE next cycle, drive shift_en_o=0 in that cycle, clear err_o, and leave max_addr outputs unchanged.
REQ-027 SHALL hold shift_en_o=1 continuously while in RUN, independent of further PPS edges.
REQ-028 SHALL never assert seq_wen_o and rng_wen_o in the same cycle.
REQ-029 SHALL drive state_o equal to the registered state.

Reset
REQ-030 SHALL on tx_core_reset=1 at a clock edge set: state IDLE, cmd_tready=0 during reset, all wen 0, addr/din 0, max_addr outputs 0, shift_en_o 0, err_o 0, timeout counter 0, PPS history 0.
REQ-031 SHALL when reset is asserted mid-operation (any state, including during a wen cycle) abandon the operation with no further wen pulse.

Verification
REQ-032 SHALL cover: SEQ_WR addr 0 data 0xA, SEQ_WR addr 5, RNG_WR addr 3, COMMIT -> one wen pulse each, max_addr_seq_o=5, max_addr_rng_o=3, state_o=2.
REQ-033 SHALL cover: armed, pps_i rises at cycle T -> shift_en_o=1 and state_o=3 at T+1; a PPS edge coincident with the COMMIT cycle produces no transition.
REQ-034 SHALL cover: SEQ_WR addr 1024 and RNG_WR addr 4096 -> no wen, err_o=1; subsequent ABORT -> err_o=0, state_o=0.
REQ-035 SHALL cover: PPS_TIMEOUT=100, COMMIT, no PPS -> after 100 cycles err_o=1, state_o=1, shift_en_o=0.
REQ-036 SHALL cover: in RUN, SEQ_WR and COMMIT -> err_o=1, no wen, shift_en_o stays 1; ABORT -> shift_en_o=0 the next cycle.
REQ-037 SHALL cover: tx_core_reset asserted for 1 cycle during RUN -> all outputs at reset values the following cycle.
